// File: rtl/tiny_rv_pipe_ctrl_if.sv
// Decode, execute and writeback signals exchanged between the tiny_rv pipeline and its
// sequencing controller. The pipeline side is master and the controller is slave.
interface tiny_rv_pipe_ctrl_if;
    logic [6:0]  decode_opcode;
    logic [4:0]  decode_rs1;
    logic [4:0]  decode_rs2;
    logic [4:0]  decode_rd;
    logic        i_ex_redirect;
    logic        i_mem_busy;
    logic        i_load_wb;
    logic [4:0]  i_load_wb_rd;
    logic        o_pipe_stall;
    logic        o_pipe_flush;
    logic [31:0] o_sb_pending;

    modport master (
        output decode_opcode, decode_rs1, decode_rs2, decode_rd,
        output i_ex_redirect, i_mem_busy, i_load_wb, i_load_wb_rd,
        input  o_pipe_stall, o_pipe_flush, o_sb_pending
    );

    modport slave (
        input  decode_opcode, decode_rs1, decode_rs2, decode_rd,
        input  i_ex_redirect, i_mem_busy, i_load_wb, i_load_wb_rd,
        output o_pipe_stall, o_pipe_flush, o_sb_pending
    );
endinterface

// File: rtl/tiny_rv_pipe_ctrl.sv
// tiny_rv pipeline stall/flush sequencer with load-use scoreboard.
// Optional TINY_RV_PIPE_PERF_EN adds stall/flush cycle counters.
module tiny_rv_pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
`ifdef TINY_RV_PIPE_PERF_EN
    output logic [31:0]          o_stall_cycles,
    output logic [31:0]          o_flush_cycles,
`endif
    tiny_rv_pipe_ctrl_if.slave   bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [3:0] CNT_RELOAD  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:1] r_pending;
    logic [31:1] w_pending_nxt;

    logic [31:0] w_pend_full;
    logic [31:0] w_set_vec;
    logic [31:0] w_clr_vec;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_hazard;
    logic        w_flush;
    logic        w_stall;
    logic        w_advance;

    // Bit 0 is tied low so x0 can never look pending.
    assign w_pend_full = {r_pending, 1'b0};

    always_comb begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        if ((bus.decode_opcode == OP_LUI) || (bus.decode_opcode == OP_AUIPC) ||
            (bus.decode_opcode == OP_JAL)) begin
            w_rs1_used = 1'b0;
        end
        if ((bus.decode_opcode == OP_BRANCH) || (bus.decode_opcode == OP_STORE) ||
            (bus.decode_opcode == OP_OP)) begin
            w_rs2_used = 1'b1;
        end
    end

    assign w_hazard  = (w_rs1_used & w_pend_full[bus.decode_rs1]) |
                       (w_rs2_used & w_pend_full[bus.decode_rs2]);
    assign w_flush   = bus.i_ex_redirect | (r_state == FLUSH);
    assign w_stall   = ~w_flush & (bus.i_mem_busy | w_hazard);
    assign w_advance = ~w_stall & ~w_flush;

    assign bus.o_pipe_flush = w_flush;
    assign bus.o_pipe_stall = w_stall;
    assign bus.o_sb_pending = w_pend_full;

    // Set is OR-ed after the clear so a same-cycle set on the same index wins.
    always_comb begin
        w_set_vec = 32'd0;
        w_clr_vec = 32'd0;
        if (w_advance && (bus.decode_opcode == OP_LOAD) && (bus.decode_rd != 5'd0)) begin
            w_set_vec = 32'd1 << bus.decode_rd;
        end
        if (bus.i_load_wb && (bus.i_load_wb_rd != 5'd0)) begin
            w_clr_vec = 32'd1 << bus.i_load_wb_rd;
        end
        w_pending_nxt = (r_pending & ~w_clr_vec[31:1]) | w_set_vec[31:1];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (bus.i_ex_redirect && MULTI_FLUSH) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = CNT_RELOAD;
                end
            end
            FLUSH: begin
                if (bus.i_ex_redirect && MULTI_FLUSH) begin
                    w_cnt_nxt = CNT_RELOAD;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= RUN;
            r_cnt     <= 4'd0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
        end
    end

`ifdef TINY_RV_PIPE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_cycles <= 32'd0;
        end else begin
            r_stall_cycles <= r_stall_cycles + 32'(w_stall);
            r_flush_cycles <= r_flush_cycles + 32'(w_flush);
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: doc/tiny_rv_pipe_ctrl.md
# tiny_rv_pipe_ctrl

Pipeline sequencing controller for the tiny_rv core. It generates the shared `o_pipe_stall` / `o_pipe_flush` controls consumed by the decode stage and by the other pipeline registers. It holds a load scoreboard that detects load-use hazards on the instruction sitting in decode, and sequences multi-cycle flushes after execute-stage redirects. It also stalls the pipe while the data-memory port is busy.

## Interface
- `FLUSH_CYCLES`, 2: cycles `o_pipe_flush` stays high per redirect; legal range 1..15.
- `i_clk`  in  1  core clock, all state on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `decode_opcode`  in  7  opcode of instruction in decode.
- `decode_rs1`  in  5  rs1 field in decode.
- `decode_rs2`  in  5  rs2 field in decode.
- `decode_rd`  in  5  rd field in decode.
- `i_ex_redirect`  in  1  execute resolved a taken branch/JAL/JALR; one-cycle pulse.
- `i_mem_busy`  in  1  data-memory stage cannot accept/complete this cycle.
- `i_load_wb`  in  1  a load is writing back this cycle.
- `i_load_wb_rd`  in  5  destination of that writeback.
- `o_pipe_stall`  out  1  hold fetch/decode registers.
- `o_pipe_flush`  out  1  clear fetch/decode registers.
- `o_sb_pending`  out  32  scoreboard bit vector; bit 0 is constant 0.

## Operation
- Reset (async, `i_reset_n`=0):
  - State = RUN, flush counter = 0, scoreboard = 0.
  - `o_pipe_stall`=0, `o_pipe_flush`=0, `o_sb_pending`=0.
- FSM states:
  - RUN: normal issue.
  - FLUSH: counter counts down remaining flush cycles.
- State transitions:
  - RUN→FLUSH on `i_ex_redirect` when `FLUSH_CYCLES`>1; counter loads `FLUSH_CYCLES`-1.
  - In FLUSH, counter decrements each cycle; exits to RUN when counter=1 is consumed.
  - `i_ex_redirect` while in FLUSH reloads the counter to `FLUSH_CYCLES`-1.
- `o_pipe_flush` = `i_ex_redirect` | (state==FLUSH).
- Advance = !`o_pipe_stall` & !`o_pipe_flush`.
  - On advance, if `decode_opcode`==7'b0000011 (LOAD) and `decode_rd`!=0, set `pending[decode_rd]`.
- Scoreboard clear: `i_load_wb` with `i_load_wb_rd`!=0 clears `pending[i_load_wb_rd]`.
  - Set and clear of the same index in one cycle: set wins.
- rs1 is a source for all opcodes except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- rs2 is a source only for BRANCH (1100011), STORE (0100011) and OP (0110011).
- Register x0 never causes a hazard.
- hazard = (rs1 used & `pending[decode_rs1]`) | (rs2 used & `pending[decode_rs2]`).
  - Computed from the registered scoreboard only; no writeback bypass.
- `o_pipe_stall` = !`o_pipe_flush` & (`i_mem_busy` | hazard).
  - Flush has priority over stall.
- Flush does not touch the scoreboard. Loads already past decode still write back.

## Timing
- Stall and flush outputs are combinational from registered state and same-cycle inputs; zero-cycle latency.
- Scoreboard updates become visible the cycle after the setting/clearing edge.
- Load-use gap: a consumer directly behind a load stalls from the cycle after the load advances until the cycle after `i_load_wb` for that rd.
- Total flush per isolated redirect = exactly `FLUSH_CYCLES` cycles.
- Reset deasserted mid-flush or mid-stall: the controller restarts in RUN with an empty scoreboard. Stale in-flight loads must be squashed by the surrounding pipeline reset.

## Configuration
- `TINY_RV_PIPE_PERF_EN` defined: adds outputs `o_stall_cycles` (32) and `o_flush_cycles` (32).
  - Each increments on every cycle its respective output is high.
  - Both wrap at 2^32-1 → 0 and reset to 0.
- Macro undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with idle inputs → stall=0, flush=0, `o_sb_pending`=0 for 10 cycles.
- LOAD rd=5 advances, then ADD x6,x5,x1 in decode:
  - stall=1 until `i_load_wb`=1/rd=5, plus one more cycle, then stall=0.
  - `pending[5]` clears.
- `i_ex_redirect` pulse with `FLUSH_CYCLES`=2 → flush high exactly 2 cycles, stall forced 0 even with `i_mem_busy`=1.
  - A second redirect in flush cycle 2 → flush extends 2 more cycles.
- LOAD rd=0 advance → scoreboard unchanged.
  - LUI in decode with `decode_rs1`=pending reg → no stall.
- Same-cycle set `pending[7]` and writeback rd=7 → `pending[7]`=1 afterwards.
- With `TINY_RV_PIPE_PERF_EN`: 3 stall cycles + 2 flush cycles → counters read 3 and 2; async reset mid-run zeroes all state immediately.
